// File: rtl/plic_defines.sv
// Shared constants for the platform-level interrupt controller:
// register offsets, default widths and the gateway mode encoding.
package plic_defines;

  localparam int DEF_NUM_SRC = 8;
  localparam int DEF_PRIO_W  = 3;
  localparam int DEF_ID_W    = 5;
  localparam int ID_NONE     = 0;

  localparam logic [11:0] ADDR_PRIO_BASE = 12'h000;
  localparam logic [11:0] ADDR_PENDING   = 12'h080;
  localparam logic [11:0] ADDR_ENABLE    = 12'h100;
  localparam logic [11:0] ADDR_THRESH    = 12'h104;
  localparam logic [11:0] ADDR_CLAIM     = 12'h108;
  localparam logic [11:0] ADDR_MODE      = 12'h10C;

  typedef enum logic {
    GW_LEVEL = 1'b0,
    GW_EDGE  = 1'b1
  } gw_mode_e;

  // Priority register of source k lives at word k.
  function automatic logic [11:0] prio_addr(input int k);
    return ADDR_PRIO_BASE + 12'(4 * k);
  endfunction

endpackage

// File: rtl/plic_ctrl_if.sv
// Memory-mapped register port of the interrupt controller.
interface plic_ctrl_if;
  logic        reg_wen;
  logic        reg_ren;
  logic [11:0] reg_addr;
  logic [31:0] reg_wdata;
  logic [31:0] reg_rdata;

  modport master (
    output reg_wen, reg_ren, reg_addr, reg_wdata,
    input  reg_rdata
  );

  modport slave (
    input  reg_wen, reg_ren, reg_addr, reg_wdata,
    output reg_rdata
  );
endinterface

// File: rtl/plic_gateway.sv
// Per-source gateway: turns a level or edge request into a pending bit,
// gated by the in-service flag, with a one-deep latch for edges seen in service.
module plic_gateway
  import plic_defines::*;
(
  input  logic clk,
  input  logic rstn,
  input  logic src_i,
  input  logic mode_i,
  input  logic claim_hit_i,
  input  logic complete_hit_i,
  output logic pending_o
);

  logic src_d_q, pend_q, is_q, latch_q, mode_q;
  logic pend_d, is_d, latch_d;
  logic rise, edge_mode;

  always_comb begin
    edge_mode = (gw_mode_e'(mode_i) == GW_EDGE);
    rise      = src_i & ~src_d_q;
    pend_d    = pend_q;
    is_d      = is_q;
    latch_d   = latch_q;
    if (edge_mode) begin
      if (rise && !is_q) pend_d = 1'b1;
      // An edge arriving while (or as) the source is in service is parked.
      if (rise && (is_q || claim_hit_i)) latch_d = 1'b1;
      else if (!is_q && latch_q) begin
        pend_d  = 1'b1;
        latch_d = 1'b0;
      end
    end else if (src_i && !is_q) begin
      pend_d = 1'b1;
    end
    if (claim_hit_i) begin
      pend_d = 1'b0;
      is_d   = 1'b1;
    end else if (complete_hit_i) begin
      is_d = 1'b0;
    end
    if (mode_i != mode_q) latch_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      src_d_q <= 1'b0;
      pend_q  <= 1'b0;
      is_q    <= 1'b0;
      latch_q <= 1'b0;
      mode_q  <= 1'b0;
    end else begin
      src_d_q <= src_i;
      pend_q  <= pend_d;
      is_q    <= is_d;
      latch_q <= latch_d;
      mode_q  <= mode_i;
    end
  end

  assign pending_o = pend_q;

endmodule

// File: rtl/plic_ctrl.sv
// Platform-level interrupt controller: register file, per-source gateways,
// priority arbiter and claim/complete handshake driving one external irq.
module plic_ctrl
  import plic_defines::*;
#(
  parameter int NUM_SRC = DEF_NUM_SRC,
  parameter int PRIO_W  = DEF_PRIO_W,
  parameter int ID_W    = DEF_ID_W
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [NUM_SRC-1:0] irq_src,
  plic_ctrl_if.slave         bus,
  output logic               ext_irq_o,
  output logic [ID_W-1:0]    claim_id_o
);

  logic [NUM_SRC-1:0][PRIO_W-1:0] prio_q, prio_d;
  logic [NUM_SRC-1:0]             en_q, en_d, mode_q, mode_d;
  logic [PRIO_W-1:0]              thr_q, thr_d;
  logic [31:0]                    rdata_q, rd_d;
  logic [ID_W-1:0]                claim_id_q, best_id;
  logic [PRIO_W-1:0]              best_prio;
  logic                           ext_irq_q;

  logic [NUM_SRC-1:0] pend, cand, claim_hit, complete_hit;
  logic               claim_rd, cmpl_wr;
  logic               unused_wdata;

  assign claim_rd     = bus.reg_ren && (bus.reg_addr == ADDR_CLAIM);
  assign cmpl_wr      = bus.reg_wen && (bus.reg_addr == ADDR_CLAIM);
  assign unused_wdata = ^bus.reg_wdata;

  // Register file writes.
  always_comb begin
    prio_d = prio_q;
    en_d   = en_q;
    thr_d  = thr_q;
    mode_d = mode_q;
    if (bus.reg_wen) begin
      for (int k = 1; k <= NUM_SRC; k++)
        if (bus.reg_addr == prio_addr(k)) prio_d[k-1] = bus.reg_wdata[PRIO_W-1:0];
      case (bus.reg_addr)
        ADDR_ENABLE: en_d   = bus.reg_wdata[NUM_SRC:1];
        ADDR_THRESH: thr_d  = bus.reg_wdata[PRIO_W-1:0];
        ADDR_MODE:   mode_d = bus.reg_wdata[NUM_SRC:1];
        default: ;
      endcase
    end
  end

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    assign cand[g]         = pend[g] & en_q[g] & (prio_q[g] > thr_q);
    assign claim_hit[g]    = claim_rd && (best_id == ID_W'(g + 1));
    assign complete_hit[g] = cmpl_wr && (bus.reg_wdata[ID_W-1:0] == ID_W'(g + 1));

    plic_gateway u_gw (
      .clk            (clk),
      .rstn           (rstn),
      .src_i          (irq_src[g]),
      .mode_i         (mode_q[g]),
      .claim_hit_i    (claim_hit[g]),
      .complete_hit_i (complete_hit[g]),
      .pending_o      (pend[g])
    );
  end

  // Candidates always have priority above zero; strict compare keeps lowest ID on ties.
  always_comb begin
    best_id   = ID_W'(ID_NONE);
    best_prio = '0;
    for (int i = 0; i < NUM_SRC; i++)
      if (cand[i] && (prio_q[i] > best_prio)) begin
        best_id   = ID_W'(i + 1);
        best_prio = prio_q[i];
      end
  end

  // Read mux sees pre-write state; bit 0 of every mask is the unused ID 0.
  always_comb begin
    rd_d = '0;
    for (int k = 1; k <= NUM_SRC; k++)
      if (bus.reg_addr == prio_addr(k)) rd_d = 32'(prio_q[k-1]);
    case (bus.reg_addr)
      ADDR_PENDING: rd_d = 32'({pend, 1'b0});
      ADDR_ENABLE:  rd_d = 32'({en_q, 1'b0});
      ADDR_THRESH:  rd_d = 32'(thr_q);
      ADDR_CLAIM:   rd_d = 32'(best_id);
      ADDR_MODE:    rd_d = 32'({mode_q, 1'b0});
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      prio_q     <= '0;
      en_q       <= '0;
      thr_q      <= '0;
      mode_q     <= '0;
      rdata_q    <= '0;
      claim_id_q <= '0;
      ext_irq_q  <= 1'b0;
    end else begin
      prio_q     <= prio_d;
      en_q       <= en_d;
      thr_q      <= thr_d;
      mode_q     <= mode_d;
      if (bus.reg_ren) rdata_q <= rd_d;
      claim_id_q <= best_id;
      ext_irq_q  <= (best_id != ID_W'(ID_NONE));
    end
  end

  assign bus.reg_rdata = rdata_q;
  assign ext_irq_o     = ext_irq_q;
  assign claim_id_o    = claim_id_q;

endmodule

// File: tb/tb_plic_ctrl.sv
// Directed bench for plic_ctrl: register reads are checked through an
// expectation queue, outputs are checked one cycle phase after the clock edge.
module tb_plic_ctrl;

  logic       clk;
  logic       rstn;
  logic [7:0] irq_src;
  logic       ext_irq;
  logic [4:0] claim_id;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;
  exp_t sb[$];

  plic_ctrl_if bus();

  plic_ctrl #(.NUM_SRC(8), .PRIO_W(3), .ID_W(5)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .irq_src    (irq_src),
    .bus        (bus),
    .ext_irq_o  (ext_irq),
    .claim_id_o (claim_id)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    bus.reg_wen   = 1'b1;
    bus.reg_addr  = a;
    bus.reg_wdata = d;
    cyc();
    bus.reg_wen   = 1'b0;
  endtask

  task automatic rd(input logic [11:0] a, input logic [31:0] e, input string tag);
    exp_t x;
    bus.reg_ren  = 1'b1;
    bus.reg_addr = a;
    x.tag = tag;
    x.exp = e;
    sb.push_back(x);
    cyc();
    bus.reg_ren = 1'b0;
    x = sb.pop_front();
    chk(x.tag, bus.reg_rdata, x.exp);
  endtask

  task automatic out(input string tag, input logic e_irq, input logic [4:0] e_id);
    chk({tag, "_irq"}, 32'(ext_irq), 32'(e_irq));
    chk({tag, "_id"}, 32'(claim_id), 32'(e_id));
  endtask

  task automatic pulse(input int s);
    irq_src[s-1] = 1'b1;
    cyc();
    irq_src[s-1] = 1'b0;
    cyc();
  endtask

  initial begin
    rstn          = 1'b0;
    irq_src       = '0;
    bus.reg_wen   = 1'b0;
    bus.reg_ren   = 1'b0;
    bus.reg_addr  = '0;
    bus.reg_wdata = '0;
    #12;
    out("reset", 1'b0, 5'd0);
    chk("reset_rdata", bus.reg_rdata, 32'h0);
    rstn = 1'b1;
    cyc();

    // Level source 3: two-cycle assertion, claim, re-pend after complete.
    wr(12'h00C, 32'd2);
    wr(12'h100, 32'h08);
    wr(12'h104, 32'd0);
    rd(12'h00C, 32'd2, "prio3_rd");
    rd(12'h100, 32'h08, "en_rd");
    irq_src[2] = 1'b1;
    cyc();
    out("lvl_1cyc", 1'b0, 5'd0);
    cyc();
    out("lvl_2cyc", 1'b1, 5'd3);
    rd(12'h108, 32'd3, "claim3");
    cyc();
    out("claim3_drop", 1'b0, 5'd0);
    rd(12'h080, 32'h0, "pend_is3");
    wr(12'h108, 32'd3);
    out("cmpl3_0", 1'b0, 5'd0);
    cyc();
    out("cmpl3_1", 1'b0, 5'd0);
    cyc();
    out("cmpl3_2", 1'b1, 5'd3);
    irq_src[2] = 1'b0;
    rd(12'h108, 32'd3, "claim3b");
    wr(12'h108, 32'd3);

    // Priority ordering with a tie between sources 2 and 6.
    wr(12'h008, 32'd5);
    wr(12'h018, 32'd5);
    wr(12'h010, 32'd7);
    wr(12'h100, 32'h54);
    irq_src = 8'b0010_1010;
    cyc();
    irq_src = '0;
    cyc();
    out("prio_mix", 1'b1, 5'd4);
    rd(12'h080, 32'h54, "pend_mix");
    rd(12'h108, 32'd4, "claim_a");
    rd(12'h108, 32'd2, "claim_b");
    rd(12'h108, 32'd6, "claim_c");
    rd(12'h108, 32'd0, "claim_none");
    out("mix_idle", 1'b0, 5'd0);
    wr(12'h108, 32'd2);
    wr(12'h108, 32'd4);
    wr(12'h108, 32'd6);

    // Threshold equal to priority blocks; disabling drops irq but keeps pending.
    wr(12'h104, 32'd5);
    wr(12'h004, 32'd5);
    wr(12'h100, 32'h02);
    pulse(1);
    out("thr_block", 1'b0, 5'd0);
    rd(12'h080, 32'h02, "pend_thr");
    rd(12'h104, 32'd5, "thr_rd");
    wr(12'h104, 32'd4);
    out("thr_lower0", 1'b0, 5'd0);
    cyc();
    out("thr_lower1", 1'b1, 5'd1);
    wr(12'h100, 32'h0);
    out("dis0", 1'b1, 5'd1);
    cyc();
    out("dis1", 1'b0, 5'd0);
    rd(12'h080, 32'h02, "pend_kept");
    wr(12'h100, 32'h02);
    rd(12'h108, 32'd1, "claim1");
    wr(12'h108, 32'd1);
    wr(12'h104, 32'd0);

    // Edge source 5: edges in service are latched once and replayed after complete.
    wr(12'h014, 32'd3);
    wr(12'h10C, 32'h20);
    wr(12'h100, 32'h20);
    rd(12'h10C, 32'h20, "mode_rd");
    pulse(5);
    rd(12'h080, 32'h20, "edge_pend");
    rd(12'h108, 32'd5, "claim5");
    pulse(5);
    pulse(5);
    rd(12'h080, 32'h0, "edge_held");
    wr(12'h108, 32'd5);
    rd(12'h080, 32'h0, "edge_cmpl0");
    rd(12'h080, 32'h20, "edge_cmpl1");
    rd(12'h108, 32'd5, "claim5b");
    cyc();
    rd(12'h080, 32'h0, "edge_once");
    pulse(5);
    rd(12'h080, 32'h0, "edge_l2");
    wr(12'h108, 32'd5);
    cyc();
    rd(12'h080, 32'h20, "edge_relatch");
    rd(12'h108, 32'd5, "claim5c");
    pulse(5);
    wr(12'h10C, 32'h0);
    wr(12'h10C, 32'h20);
    wr(12'h108, 32'd5);
    cyc();
    rd(12'h080, 32'h0, "mode_clr");

    // Bogus completes leave source 2 in service; unmapped accesses are inert.
    wr(12'h008, 32'd1);
    wr(12'h100, 32'h14);
    pulse(2);
    rd(12'h108, 32'd2, "claim2");
    wr(12'h108, 32'd7);
    wr(12'h108, 32'd0);
    wr(12'h108, 32'd9);
    irq_src[1] = 1'b1;
    cyc();
    cyc();
    rd(12'h080, 32'h0, "bogus_cmpl");
    rd(12'h1F0, 32'h0, "unmapped");
    wr(12'h1F0, 32'hFFFF_FFFF);
    rd(12'h000, 32'h0, "prio0");
    rd(12'h104, 32'h0, "thr_after_unmapped");

    // Asynchronous reset while source 2 is in service and source 4 is asserting.
    pulse(4);
    out("pre_rst", 1'b1, 5'd4);
    rd(12'h008, 32'd1, "prio2_pre");
    rstn = 1'b0;
    #2;
    out("rst_async", 1'b0, 5'd0);
    chk("rst_async_rdata", bus.reg_rdata, 32'h0);
    #8;
    irq_src = '0;
    rstn    = 1'b1;
    cyc();
    rd(12'h00C, 32'h0, "rst_prio3");
    rd(12'h008, 32'h0, "rst_prio2");
    rd(12'h080, 32'h0, "rst_pend");
    rd(12'h100, 32'h0, "rst_en");
    out("rst_after", 1'b0, 5'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/plic_ctrl.md
Name: plic_ctrl

Overview:
Parametrised platform-level interrupt controller that replaces the fixed 4-bit plic_irq input path of the core.
- Accepts NUM_SRC external interrupt sources, each with per-source level/edge gateway, priority, enable, global threshold and claim/complete handshake.
- Drives one external interrupt request into the core's commit logic.
- Exposes a 32-bit memory-mapped register port on the data bus.

Parameters:
NUM_SRC, 8, number of interrupt sources (1..31); source IDs 1..NUM_SRC, ID 0 = "no interrupt"
PRIO_W, 3, priority field width; priority 0 = source never interrupts
ID_W, 5, width of claim ID

Ports:
clk  input  1  core clock
rstn  input  1  asynchronous active-low reset
irq_src  input  NUM_SRC  source requests, synchronous to clk; bit i = source ID i+1
reg_wen  input  1  register write strobe
reg_ren  input  1  register read strobe
reg_addr  input  12  byte address within block, word aligned
reg_wdata  input  32  write data
reg_rdata  output  32  read data, valid cycle after reg_ren
ext_irq_o  output  1  interrupt request to commit logic
claim_id_o  output  ID_W  registered ID of current best candidate (0 if none)

Behaviour:
- Reset: all priority, enable, edge-mode, pending, in-service, edge-latch and threshold registers = 0; ext_irq_o = 0, claim_id_o = 0, reg_rdata = 0.
- Register map:
  - 0x000+4*k: priority of source k (k = 1..NUM_SRC), bits [PRIO_W-1:0] R/W, rest read 0.
  - 0x080: pending, bit k = source k, read-only.
  - 0x100: enable bits, R/W.
  - 0x104: threshold [PRIO_W-1:0], R/W.
  - 0x108: read = claim, write = complete.
  - 0x10C: edge-mode mask, bit k: 1 = edge, 0 = level.
  - Unmapped reads return 0; unmapped writes are ignored. Bit 0 of every bitmask reads 0.
- Gateway per source, gated by in-service bit IS[k]:
  - Level mode: pending set while src high and IS=0.
  - Edge mode: rising edge (src & ~src_d) sets pending if IS=0. If IS=1 it sets the one-deep edge latch; further edges are dropped. On complete, a set latch moves to pending in the following cycle and the latch clears.
  - Switching mode clears the edge latch.
- Arbiter (combinational):
  - Candidate = pending & enable & (prio > threshold).
  - Best = highest priority candidate; ties go to the lowest ID.
  - claim_id_o and ext_irq_o (= best != 0) are registered: 1-cycle latency from any state change.
- Claim (reg_ren at 0x108):
  - reg_rdata = combinational best ID in that cycle.
  - Same edge: pending[best] cleared, IS[best] set.
  - Claim with no candidate returns 0 and changes nothing.
- Complete (reg_wen at 0x108, wdata[ID_W-1:0] = k):
  - Clears IS[k] if set.
  - IDs 0, > NUM_SRC or not in service are ignored.
- Simultaneous events:
  - reg_wen and reg_ren in one cycle: the read sees pre-write state.
  - Claim and new edge on the same source in one cycle: pending clears and the edge goes to the edge latch.
  - Level source still high after complete: re-pends the next cycle.
- Disabling, or lowering priority of, a pending source deasserts ext_irq_o at the next edge; pending is retained.
- Reset mid-operation: all state clears immediately, asynchronously; in-flight claims are lost.

Decomposition:
- Package plic_defines: register offsets, PRIO_W/ID_W defaults, ID_NONE = 0.
- Sub-module plic_gateway: one instance per source via generate. It holds src_d, pending, IS and the edge latch. Inputs: mode, claim_hit, complete_hit.
- The top level holds the register file, arbiter and read mux.

Test Plan:
- Level src 3, prio 2, enable bit 3, threshold 0 → ext_irq_o=1 two cycles after src rises; claim reads 3; ext_irq_o=0 next cycle; complete 3 with src still high → re-asserts 2 cycles later.
- Sources 2 (prio 5) and 6 (prio 5) and 4 (prio 7) pending, all enabled → claims return 4, then 2, then 6; the fourth claim returns 0.
- Threshold 5, source 1 prio 5 pending → ext_irq_o stays 0; threshold 4 → ext_irq_o=1 one cycle later.
- Edge src 5, two pulses while in service → pending 0 until complete 5; pending[5]=1 the following cycle, only once; a third pulse after that claim is latched again.
- Complete 7 when IS[7]=0, and complete 0 → no state change. Read 0x1F0 → 0.
- Assert rstn low for one cycle while IS[2]=1 and ext_irq_o=1 → all outputs 0 asynchronously; after release, priority reads 0 and pending reads 0.
